// File: rtl/morfoloji_pkg.sv
// morfoloji_pkg
// Shared definitions for the morphology unit.
//   MOD_*     : operation codes carried on mod_i
//   durum_t   : FSM state encoding (BOS idle, TARA scan, CIKIS result held)
//   kimlik()  : identity element of the reduction for a given operation,
//               used both to seed the accumulator and to pad unused lanes
package morfoloji_pkg;

  localparam logic [1:0] MOD_EROZ = 2'd0;
  localparam logic [1:0] MOD_GENL = 2'd1;
  localparam logic [1:0] MOD_MIN  = 2'd2;
  localparam logic [1:0] MOD_MAX  = 2'd3;

  localparam int MAX_PIX_W = 16;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    TARA  = 2'd1,
    CIKIS = 2'd2
  } durum_t;

  // All-ones (low pix_w bits) for the min-like operations, zero for the
  // max-like ones. Callers keep only the low pix_w bits of the result.
  function automatic logic [MAX_PIX_W-1:0] kimlik(input logic [1:0] mode,
                                                  input int pix_w);
    logic [MAX_PIX_W-1:0] r;
    if (mode == MOD_EROZ || mode == MOD_MIN)
      r = {MAX_PIX_W{1'b1}} >> (MAX_PIX_W - pix_w);
    else
      r = '0;
    return r;
  endfunction

endpackage

// File: rtl/morfoloji_islem_if.sv
// morfoloji_islem_if
// Window-in / pixel-out handshake bundle of the morphology unit.
//   mod_i, pencere_i, valid_i : window transaction from the window generator
//   ready_o                   : unit can accept a window
//   veri_o, valid_o           : result pixel towards the pixel writer
//   ready_i                   : pixel writer accepts the result
// slave is the unit side, master the upstream/downstream side.
interface morfoloji_islem_if #(
  parameter int PIX_W = 8,
  parameter int N     = 9
);

  logic [1:0]         mod_i;
  logic [N*PIX_W-1:0] pencere_i;
  logic               valid_i;
  logic               ready_o;
  logic [PIX_W-1:0]   veri_o;
  logic               valid_o;
  logic               ready_i;

  modport master (
    output mod_i, pencere_i, valid_i, ready_i,
    input  ready_o, veri_o, valid_o
  );

  modport slave (
    input  mod_i, pencere_i, valid_i, ready_i,
    output ready_o, veri_o, valid_o
  );

endinterface

// File: rtl/morfoloji_serit.sv
// morfoloji_serit
// Combinational LANES-wide reduction over one group of window taps.
//   taps_i  : LANES taps, lane l at bits [l*PIX_W +: PIX_W]
//   mask_i  : per-lane valid; masked lanes behave as the identity element
//   mod_i   : operation code
//   deger_o : min (MOD_MIN) or max (MOD_MAX) of the valid lanes
//   karar_o : a valid lane decides a binary result on its own
//             (zero tap for erosion, nonzero tap for dilation)
module morfoloji_serit
  import morfoloji_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int LANES = 3
) (
  input  logic [LANES*PIX_W-1:0] taps_i,
  input  logic [LANES-1:0]       mask_i,
  input  logic [1:0]             mod_i,
  output logic [PIX_W-1:0]       deger_o,
  output logic                   karar_o
);

  logic [PIX_W-1:0] tap;

  // Start from the identity so masked lanes never influence the result.
  always_comb begin
    deger_o = PIX_W'(kimlik(mod_i, PIX_W));
    karar_o = 1'b0;
    tap     = '0;
    for (int l = 0; l < LANES; l++) begin
      tap = taps_i[l*PIX_W +: PIX_W];
      if (mask_i[l]) begin
        case (mod_i)
          MOD_EROZ: if (tap == '0) karar_o = 1'b1;
          MOD_GENL: if (tap != '0) karar_o = 1'b1;
          MOD_MIN:  if (tap < deger_o) deger_o = tap;
          default:  if (tap > deger_o) deger_o = tap;
        endcase
      end
    end
  end

endmodule

// File: rtl/morfoloji_islem.sv
// morfoloji_islem
// WIN x WIN morphology unit: binary erosion/dilation, gray min/max.
// One window per transaction; LANES taps are folded per scan cycle, and the
// binary modes stop at the first group holding a decisive tap.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   en_i   : block enable, low aborts and clears on the next edge
//   bus    : morfoloji_islem_if.slave (window in, result out)
module morfoloji_islem
  import morfoloji_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int WIN   = 3,
  parameter int LANES = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  morfoloji_islem_if.slave  bus
);

  localparam int N     = WIN * WIN;
  localparam int S     = (N + LANES - 1) / LANES;
  localparam int IDX_W = $clog2(S * LANES + 1);

  durum_t             durum_q;
  logic [N*PIX_W-1:0] pencere_q;
  logic [1:0]         mod_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PIX_W-1:0]   acc_q;
  logic [PIX_W-1:0]   veri_q;
  logic               valid_q;
  logic               bos_q;

  logic [LANES*PIX_W-1:0] serit_taps;
  logic [LANES-1:0]       serit_mask;
  logic [PIX_W-1:0]       serit_deger;
  logic                   serit_karar;
  logic [PIX_W-1:0]       katla;
  logic                   son_grup;

  // Select taps [idx, idx+LANES); lanes past the last tap are masked off.
  always_comb begin
    serit_taps = '0;
    serit_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      if (int'(idx_q) + l < N) begin
        serit_taps[l*PIX_W +: PIX_W] = pencere_q[(int'(idx_q) + l)*PIX_W +: PIX_W];
        serit_mask[l] = 1'b1;
      end
    end
  end

  morfoloji_serit #(
    .PIX_W (PIX_W),
    .LANES (LANES)
  ) u_serit (
    .taps_i  (serit_taps),
    .mask_i  (serit_mask),
    .mod_i   (mod_q),
    .deger_o (serit_deger),
    .karar_o (serit_karar)
  );

  // In binary modes the accumulator keeps its identity seed, which is
  // exactly the result when no decisive tap shows up before the end.
  always_comb begin
    katla    = acc_q;
    son_grup = (int'(idx_q) + LANES >= N);
    if (mod_q == MOD_MIN) begin
      if (serit_deger < acc_q) katla = serit_deger;
    end else if (mod_q == MOD_MAX) begin
      if (serit_deger > acc_q) katla = serit_deger;
    end
  end

  // bos_q mirrors "state is BOS" but stays low through reset so ready_o
  // only follows en_i once the block has seen a clock out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q   <= BOS;
      pencere_q <= '0;
      mod_q     <= MOD_EROZ;
      idx_q     <= '0;
      acc_q     <= '0;
      veri_q    <= '0;
      valid_q   <= 1'b0;
      bos_q     <= 1'b0;
    end else if (!en_i) begin
      durum_q   <= BOS;
      pencere_q <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      veri_q    <= '0;
      valid_q   <= 1'b0;
      bos_q     <= 1'b1;
    end else begin
      case (durum_q)
        BOS: begin
          bos_q <= 1'b1;
          if (bus.valid_i && bus.ready_o) begin
            pencere_q <= bus.pencere_i;
            mod_q     <= bus.mod_i;
            idx_q     <= '0;
            acc_q     <= PIX_W'(kimlik(bus.mod_i, PIX_W));
            durum_q   <= TARA;
            bos_q     <= 1'b0;
          end
        end
        TARA: begin
          acc_q <= katla;
          idx_q <= idx_q + IDX_W'(LANES);
          // A decisive tap flips the binary result away from the identity.
          if (serit_karar) begin
            veri_q  <= ~acc_q;
            valid_q <= 1'b1;
            durum_q <= CIKIS;
          end else if (son_grup) begin
            veri_q  <= katla;
            valid_q <= 1'b1;
            durum_q <= CIKIS;
          end
        end
        CIKIS: begin
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            durum_q <= BOS;
            bos_q   <= 1'b1;
          end
        end
        default: durum_q <= BOS;
      endcase
    end
  end

  assign bus.ready_o = en_i & bos_q;
  assign bus.veri_o  = veri_q;
  assign bus.valid_o = valid_q;

endmodule
